// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_ALUI,
    CL_BR,
    CL_JMP,
    CL_LD,
    CL_ST,
    CL_STOP,
    CL_ILL
  } iclass_t;

  localparam logic [3:0] OP_FKEQ  = 4'b0000;
  localparam logic [3:0] OP_FKNE  = 4'b0001;
  localparam logic [3:0] OP_FKLT  = 4'b0010;
  localparam logic [3:0] OP_FKLE  = 4'b0011;
  localparam logic [3:0] OP_PLUS  = 4'b0100;
  localparam logic [3:0] OP_MINUS = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_FKGT  = 4'b1000;
  localparam logic [3:0] OP_FKGE  = 4'b1001;
  localparam logic [3:0] OP_JUMP  = 4'b1010;
  localparam logic [3:0] OP_LDW   = 4'b1011;
  localparam logic [3:0] OP_STW   = 4'b1100;
  localparam logic [3:0] OP_PLUSI = 4'b1101;
  localparam logic [3:0] OP_STOP  = 4'b1110;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ILL  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: IR/datapath/memory inputs and the control strobes.
interface multicycle_ctrl_if #(
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic [OP_W-1:0]  opcode;
  logic             cmp_true;
  logic             mem_ack;
  logic             resume;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             rf_write;
  logic             rf_wsel;
  logic             alu_imm;
  logic [1:0]       alu_op;
  logic             halted;
  logic [1:0]       err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, cmp_true, mem_ack, resume,
    output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           rf_write, rf_wsel, alu_imm, alu_op, halted, err, retired
  );

  modport slave (
    output opcode, cmp_true, mem_ack, resume,
    input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
           rf_write, rf_wsel, alu_imm, alu_op, halted, err, retired
  );
endinterface

// File: rtl/ctrl_opclass.sv
// Opcode classifier: instruction class and ALU operation for one opcode.
module ctrl_opclass
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  output iclass_t         cls,
  output logic [1:0]      alu_op
);

  logic       upper;
  logic [3:0] op4;

  // Any bit above the 4-bit opcode space makes the instruction illegal.
  assign upper = (opcode >> 4) != '0;
  assign op4   = opcode[3:0];

  // Map the low nibble to a class; unlisted codes (1111) are illegal.
  always_comb begin
    cls    = CL_ILL;
    alu_op = ALU_ADD;
    if (!upper) begin
      case (op4)
        OP_FKEQ, OP_FKNE, OP_FKLT, OP_FKLE, OP_FKGT, OP_FKGE: begin
          cls    = CL_BR;
          alu_op = ALU_SUB;
        end
        OP_PLUS:  cls = CL_ALU;
        OP_MINUS: begin cls = CL_ALU; alu_op = ALU_SUB; end
        OP_AND:   begin cls = CL_ALU; alu_op = ALU_AND; end
        OP_OR:    begin cls = CL_ALU; alu_op = ALU_OR;  end
        OP_JUMP:  cls = CL_JMP;
        OP_LDW:   cls = CL_LD;
        OP_STW:   cls = CL_ST;
        OP_PLUSI: cls = CL_ALUI;
        OP_STOP:  cls = CL_STOP;
        default:  cls = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM with memory timeout, halt/resume and retire count.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   S_FETCH  | instruction read at PC; IR and PC+1 loaded on ack
//   S_DECODE | opcode latched into op_q and classified
//   S_EXEC   | ALU op / branch / jump / address calculation
//   S_MEM    | data read or write at ALU address
//   S_WB     | register-file write from ALU or memory
//   S_HALT   | stopped (stop, illegal opcode, timeout) until resume
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int TMO   = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  localparam int            TW     = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LD = TW'(TMO);

  state_t           state, nxt;
  logic [OP_W-1:0]  op_q, cls_op;
  iclass_t          cls;
  logic [1:0]       cls_alu;
  logic [TW-1:0]    wait_cnt;
  logic [1:0]       err_q, err_set;
  logic             err_clr, retire;
  logic [CNT_W-1:0] retired_q;

  logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic       rf_write, rf_wsel, alu_imm, halted;
  logic [1:0] pc_src, alu_op;

  // DECODE classifies the live opcode; later states use the latched copy.
  assign cls_op = (state == S_DECODE) ? bus.opcode : op_q;

  ctrl_opclass #(.OP_W(OP_W)) u_opclass (
    .opcode (cls_op),
    .cls    (cls),
    .alu_op (cls_alu)
  );

  // State register and opcode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) op_q <= bus.opcode;
    end
  end

  // Memory wait timer: reloaded on every state change, counts down while a request stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= TMO_LD;
    end else if (nxt == state && (state == S_FETCH || state == S_MEM)) begin
      wait_cnt <= wait_cnt - TW'(1);
    end else begin
      wait_cnt <= TMO_LD;
    end
  end

  // Sticky trap code, cleared when leaving HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= ERR_NONE;
    end else if (err_clr) begin
      err_q <= ERR_NONE;
    end else if (err_set != ERR_NONE) begin
      err_q <= err_set;
    end
  end

  // Wrapping retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next state and control strobes; everything held low while rst is asserted.
  always_comb begin
    nxt      = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_INC;
    rf_write = 1'b0;
    rf_wsel  = 1'b0;
    alu_imm  = 1'b0;
    alu_op   = ALU_ADD;
    halted   = 1'b0;
    err_set  = ERR_NONE;
    err_clr  = 1'b0;
    retire   = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (bus.mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = S_DECODE;
          end else if (wait_cnt == '0) begin
            err_set = ERR_TMO;
            nxt     = S_HALT;
          end
        end
        S_DECODE: begin
          case (cls)
            CL_STOP: begin nxt = S_HALT; retire = 1'b1; end
            CL_ILL:  begin nxt = S_HALT; err_set = ERR_ILL; end
            default: nxt = S_EXEC;
          endcase
        end
        S_EXEC: begin
          alu_op = cls_alu;
          case (cls)
            CL_ALU:  nxt = S_WB;
            CL_ALUI: begin alu_imm = 1'b1; nxt = S_WB; end
            CL_BR: begin
              pc_write = bus.cmp_true;
              pc_src   = bus.cmp_true ? PC_BR : PC_INC;
              nxt      = S_FETCH;
              retire   = 1'b1;
            end
            CL_JMP: begin
              pc_write = 1'b1;
              pc_src   = PC_JMP;
              nxt      = S_FETCH;
              retire   = 1'b1;
            end
            CL_LD, CL_ST: begin alu_imm = 1'b1; nxt = S_MEM; end
            default: nxt = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (cls == CL_ST);
          if (bus.mem_ack) begin
            if (cls == CL_LD) begin
              nxt = S_WB;
            end else begin
              nxt    = S_FETCH;
              retire = 1'b1;
            end
          end else if (wait_cnt == '0) begin
            err_set = ERR_TMO;
            nxt     = S_HALT;
          end
        end
        S_WB: begin
          rf_write = 1'b1;
          rf_wsel  = (cls == CL_LD);
          nxt      = S_FETCH;
          retire   = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
          if (bus.resume) begin
            err_clr = 1'b1;
            nxt     = S_FETCH;
          end
        end
        default: nxt = S_FETCH;
      endcase
    end
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_we   = mem_we;
  assign bus.addr_sel = addr_sel;
  assign bus.ir_write = ir_write;
  assign bus.pc_write = pc_write;
  assign bus.pc_src   = pc_src;
  assign bus.rf_write = rf_write;
  assign bus.rf_wsel  = rf_wsel;
  assign bus.alu_imm  = alu_imm;
  assign bus.alu_op   = alu_op;
  assign bus.halted   = halted;
  assign bus.err      = err_q;
  assign bus.retired  = retired_q;

endmodule
